// File: rtl/alu_pkg.sv
// Shared definitions for the y_alu datapath: default width and op-code encodings.
// The reserved-code helper keeps decode rules in one place for ALU and consumers.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Codes 011, 100 and 101 alias onto a real mux leg via op[1:0], so they are masked.
    function automatic logic is_reserved(input logic [2:0] op);
        return (op != OP_AND) && (op != OP_OR) && (op != OP_ADD) &&
               (op != OP_SUB) && (op != OP_SLT);
    endfunction

endpackage

// File: rtl/y_adder.sv
// WIDTH-bit ripple-carry adder built from 1-bit full adders.
// Shared by ADD, SUB and SLT; the caller supplies inverted b and cin=1 to subtract.
module y_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module y_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        y_full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];
endmodule

// File: rtl/y_alu.sv
// Single-cycle ALU: AND/OR/ADD/SUB/SLT with combinational z/ex and a registered copy.
// Wrap-around is silent; reserved op codes yield z=0 and therefore ex=1.
module y_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] z,
    output logic             ex,
    output logic [WIDTH-1:0] z_q,
    output logic             ex_q
);
    logic [WIDTH-1:0] b_eff;
    logic             sub_en;
    logic [WIDTH-1:0] sum;
    logic             cout_unused;
    logic             overflow;
    logic             slt;
    logic [WIDTH-1:0] z_d;
    logic             ex_d;

    // op[2] selects subtraction: a + ~b + 1 through the one shared adder.
    assign sub_en = op[2];
    assign b_eff  = sub_en ? ~b : b;

    y_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (a),
        .b    (b_eff),
        .cin  (sub_en),
        .sum  (sum),
        .cout (cout_unused)
    );

    // Signed overflow: operands share a sign that the sum does not.
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign slt      = sum[WIDTH-1] ^ overflow;

    always_comb begin
        // NOTE: default first so every path assigns z_d and no latch is inferred.
        z_d = '0;
        if (!is_reserved(op)) begin
            case (op[1:0])
                2'b00:   z_d = a & b;
                2'b01:   z_d = a | b;
                2'b10:   z_d = sum;
                default: z_d = {{(WIDTH-1){1'b0}}, slt};
            endcase
        end
    end

    assign ex_d = ~|z_d;
    assign z    = z_d;
    assign ex   = ex_d;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep register updates order-independent.
        if (!rst_n) begin
            z_q  <= '0;
            ex_q <= 1'b0;
        end else begin
            z_q  <= z_d;
            ex_q <= ex_d;
        end
    end

endmodule

// File: tb/tb_y_alu.sv
// Scoreboard bench for y_alu: stimulus pushes expected values, a monitor pops and checks.
module tb_y_alu;

    localparam int W = 32;

    typedef struct {
        string        name;
        bit           reg_path;
        logic [W-1:0] z;
        logic         ex;
    } exp_t;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] z;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] z;
    logic         ex;
    logic [W-1:0] z_q;
    logic         ex_q;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    event sample_ev;

    y_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .op    (op),
        .z     (z),
        .ex    (ex),
        .z_q   (z_q),
        .ex_q  (ex_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] z_act, input logic ex_act,
                         input logic [W-1:0] z_exp, input logic ex_exp);
        checks++;
        if (z_act !== z_exp || ex_act !== ex_exp) begin
            errors++;
            $display("FAIL %s: got z=%h ex=%b, expected z=%h ex=%b",
                     name, z_act, ex_act, z_exp, ex_exp);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [2:0] o, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        case (o)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x + y;
            3'b110:  return x - y;
            3'b111:  return ($signed(x) < $signed(y)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    task automatic expect_now(input string name, input bit reg_path,
                              input logic [W-1:0] z_exp, input logic ex_exp);
        exp_t e;
        e.name     = name;
        e.reg_path = reg_path;
        e.z        = z_exp;
        e.ex       = ex_exp;
        sb_q.push_back(e);
        ->sample_ev;
    endtask

    task automatic apply_comb(input string name, input logic [2:0] o, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [W-1:0] z_exp);
        op = o;
        a  = x;
        b  = y;
        #1;
        expect_now(name, 1'b0, z_exp, (z_exp == '0));
        #1;
    endtask

    // Monitor: pops every expectation presented and compares against the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.reg_path) check(e.name, z_q, ex_q, e.z, e.ex);
                else            check(e.name, z, ex, e.z, e.ex);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs[$];
        logic [2:0] rops[4];
        logic [W-1:0] x;
        logic [W-1:0] y;

        vecs.push_back('{"and",      3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000});
        vecs.push_back('{"or",       3'b001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0});
        vecs.push_back('{"add_wrap", 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
        vecs.push_back('{"sub_neg",  3'b110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE});
        vecs.push_back('{"sub_eq",   3'b110, 32'h12345678, 32'h12345678, 32'h00000000});
        vecs.push_back('{"sub_wrap", 3'b110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF});
        vecs.push_back('{"slt_m1_1", 3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
        vecs.push_back('{"slt_1_m1", 3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000});
        vecs.push_back('{"slt_ovf",  3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001});
        vecs.push_back('{"slt_ovf2", 3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000});
        vecs.push_back('{"slt_eq",   3'b111, 32'h00000009, 32'h00000009, 32'h00000000});
        vecs.push_back('{"rsv_011",  3'b011, 32'hDEADBEEF, 32'h12345678, 32'h00000000});
        vecs.push_back('{"rsv_100",  3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
        vecs.push_back('{"rsv_101",  3'b101, 32'h0000FFFF, 32'hFFFF0000, 32'h00000000});

        rops = '{3'b000, 3'b001, 3'b010, 3'b110};

        rst_n = 1'b0;
        op    = 3'b010;
        a     = 32'd1;
        b     = 32'd1;
        #2;
        expect_now("reset_regs", 1'b1, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply_comb(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].z);

        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 10; n++) begin
                x = $urandom;
                y = $urandom;
                apply_comb($sformatf("rand_op%0b_%0d", rops[k], n), rops[k], x, y,
                           ref_model(rops[k], x, y));
            end
        end

        // Registered path: load 5, reset asynchronously mid-cycle, then recapture.
        @(negedge clk);
        op = 3'b010;
        a  = 32'd2;
        b  = 32'd3;
        @(posedge clk);
        #1;
        expect_now("reg_load", 1'b1, 32'd5, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_now("reg_async_rst", 1'b1, '0, 1'b0);
        @(posedge clk);
        #1;
        expect_now("reg_held_rst", 1'b1, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_now("reg_first_edge", 1'b1, 32'd5, 1'b0);
        @(negedge clk);
        op = 3'b011;
        @(posedge clk);
        #1;
        expect_now("reg_zero_flag", 1'b1, '0, 1'b1);

        #2;
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
